// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM encodings, bit-period formula and frame-length constants.
// UART_TX_PARITY_EN adds the PARITY state and lengthens the frame by one bit.
package uart_tx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = 3;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // Rounded clocks per bit, so the baud error stays within half a clock
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: one-cycle bit_tick_c every CLKS_PER_BIT cycles, re-phased by restart.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_tick_c
);

    localparam int unsigned       CNT_W   = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_tick_c = (cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || bit_tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-entry holding register for gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to append a parity bit (sense chosen by PARITY_ODD).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);

    if (PARITY_ODD > 1) begin : g_parity_odd_check
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    state_t            state;
    state_t            state_next;
    logic [7:0]        hold_data;
    logic              hold_valid;
    logic              hold_valid_next;
    logic [7:0]        shift;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_tick_c;
    logic              accept_c;
    logic              load_c;
    logic              last_bit_c;
    logic              txd_next;
`ifdef UART_TX_PARITY_EN
    logic              parity_bit;
`endif

    assign accept_c   = tx_valid & tx_ready;
    assign last_bit_c = (bit_idx == IDX_W'(DATA_BITS - 1));

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .restart    (load_c),
        .bit_tick_c (bit_tick_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (hold_valid) state_next = ST_START;
            ST_START:  if (bit_tick_c) state_next = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (bit_tick_c && last_bit_c) state_next = ST_PARITY;
            ST_PARITY: if (bit_tick_c) state_next = ST_STOP;
`else
            ST_DATA:   if (bit_tick_c && last_bit_c) state_next = ST_STOP;
`endif
            ST_STOP:   if (bit_tick_c) state_next = hold_valid ? ST_START : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // txd_next is the value the line takes after this edge; load_c moves hold into shift
    always_comb begin
        load_c   = 1'b0;
        txd_next = txd;
        case (state)
            ST_IDLE: begin
                if (hold_valid) begin
                    load_c   = 1'b1;
                    txd_next = 1'b0;
                end
            end
            ST_START: if (bit_tick_c) txd_next = shift[0];
            ST_DATA: begin
                if (bit_tick_c) begin
`ifdef UART_TX_PARITY_EN
                    txd_next = last_bit_c ? parity_bit : shift[1];
`else
                    txd_next = last_bit_c ? 1'b1 : shift[1];
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_tick_c) txd_next = 1'b1;
`endif
            ST_STOP: begin
                if (bit_tick_c) begin
                    load_c   = hold_valid;
                    txd_next = ~hold_valid;
                end
            end
            default: txd_next = 1'b1;
        endcase
    end

    always_comb begin
        hold_valid_next = hold_valid;
        if (load_c)   hold_valid_next = 1'b0;
        if (accept_c) hold_valid_next = 1'b1;
    end

    // Ready drops on accept and returns one cycle after the hold empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txd        <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            shift      <= '0;
            bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            txd        <= txd_next;
            hold_valid <= hold_valid_next;
            tx_ready   <= ~hold_valid & ~accept_c;
            busy       <= (state_next != ST_IDLE) | hold_valid_next;
            if (accept_c) begin
                hold_data <= tx_data;
            end
            if (load_c) begin
                shift   <= hold_data;
                bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= (^hold_data) ^ 1'(PARITY_ODD);
`endif
            end else if (state == ST_DATA && bit_tick_c) begin
                shift   <= {1'b0, shift[7:1]};
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single frames, directed corner sequences,
// and a randomized byte stream decoded against a frame-level reference model.
module tb_uart_tx;

    localparam int unsigned CPB     = 10;
    localparam int unsigned TB_PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif
    localparam int unsigned FL      = FB * CPB;
    localparam int unsigned DEF_CPB = 217;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] line;   // [0]=start, [8:1]=data, [9]=stop
        logic       par;    // even-parity bit of data
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data, tx_data_d;
    logic       tx_valid, tx_valid_d;
    logic       tx_ready, tx_ready_d;
    logic       txd, txd_d;
    logic       busy, busy_d;

    int checks = 0;
    int errors = 0;
    logic [7:0] src_q[$];
    logic [7:0] exp_q[$];
    bit         drv_done;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ_HZ (1_000_000),
        .BAUD        (100_000),
        .PARITY_ODD  (TB_PODD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .txd      (txd),
        .busy     (busy)
    );

    uart_tx dut_def (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data_d),
        .tx_valid (tx_valid_d),
        .tx_ready (tx_ready_d),
        .txd      (txd_d),
        .busy     (busy_d)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference line value of bit slot k of a frame carrying d
    function automatic logic line_bit(input logic [7:0] d, input int unsigned k);
        logic [7:0] s;
        if (k == 0) return 1'b0;
        if (k <= 8) begin
            s = d >> (k - 1);
            return s[0];
        end
        if (FB == 11 && k == 9) return (^d) ^ 1'(TB_PODD);
        return 1'b1;
    endfunction

    function automatic logic vec_bit(input vec_t v, input int unsigned k);
        logic [9:0] s;
        if (k < 9) begin
            s = v.line >> k;
            return s[0];
        end
        if (k == FB - 1) return v.line[9];
        return v.par ^ 1'(TB_PODD);
    endfunction

    task automatic send_vec(input vec_t v, input string name);
        tx_data  = v.data;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        chk({name, "_ready_after_accept"}, 32'(tx_ready), 32'd0);
        chk({name, "_busy_after_accept"}, 32'(busy), 32'd1);
        chk({name, "_txd_before_start"}, 32'(txd), 32'd1);
        for (int unsigned c = 1; c <= FL; c++) begin
            tick;
            chk({name, "_txd"}, 32'(txd), 32'(vec_bit(v, (c - 1) / CPB)));
            chk({name, "_busy"}, 32'(busy), 32'd1);
            if (c == 1) chk({name, "_ready_n1"}, 32'(tx_ready), 32'd0);
            if (c == 2) chk({name, "_ready_n2"}, 32'(tx_ready), 32'd1);
        end
        tick;
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_txd_end"}, 32'(txd), 32'd1);
    endtask

    task automatic stream_driver(input int unsigned max_gap);
        logic [7:0]  want;
        logic        rdy;
        int unsigned guard;
        int unsigned gap;
        drv_done = 1'b0;
        while (src_q.size() > 0) begin
            want = src_q.pop_front();
            gap  = (max_gap == 0) ? 0 : $urandom_range(max_gap, 0);
            if (gap > 0) begin
                tx_valid = 1'b0;
                repeat (gap) tick;
            end
            tx_valid = 1'b1;
            guard    = 0;
            do begin
                rdy     = tx_ready;
                tx_data = rdy ? want : 8'($urandom);
                tick;
                guard++;
            end while (!rdy && guard < 4 * FL);
            chk("stream_accept", 32'(rdy), 32'd1);
            exp_q.push_back(want);
        end
        tx_valid = 1'b0;
        drv_done = 1'b1;
    endtask

    task automatic stream_checker(input int unsigned n);
        int unsigned guard;
        int unsigned bad;
        logic [7:0]  e;
        for (int unsigned f = 0; f < n; f++) begin
            guard = 0;
            do begin
                tick;
                guard++;
            end while (txd !== 1'b0 && guard < 50 * FL);
            chk("stream_frame_start", 32'(txd), 32'd0);
            if (txd !== 1'b0) return;
            chk("stream_frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() == 0) return;
            e = exp_q.pop_front();
            for (int unsigned c = 1; c <= FL; c++) begin
                if (c > 1) tick;
                chk("stream_txd", 32'(txd), 32'(line_bit(e, (c - 1) / CPB)));
            end
        end
        guard = 0;
        while (!drv_done && guard < 1000) begin
            tick;
            guard++;
        end
        bad = 0;
        repeat (3 * FL) begin
            tick;
            if (txd !== 1'b1) bad++;
        end
        chk("stream_idle_after", bad, 32'd0);
        chk("stream_all_sent", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        int unsigned guard;

        vecs[0] = '{data: 8'h55, line: 10'b1010101010, par: 1'b0};
        vecs[1] = '{data: 8'h00, line: 10'b1000000000, par: 1'b0};
        vecs[2] = '{data: 8'hFF, line: 10'b1111111110, par: 1'b0};
        vecs[3] = '{data: 8'h07, line: 10'b1000001110, par: 1'b1};
        vecs[4] = '{data: 8'h80, line: 10'b1100000000, par: 1'b1};
        vecs[5] = '{data: 8'h3C, line: 10'b1001111000, par: 1'b0};

        rst        = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
        repeat (3) tick;
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_ready", 32'(tx_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) tick;
        chk("post_reset_txd", 32'(txd), 32'd1);
        chk("post_reset_ready", 32'(tx_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Single frames from idle, exact per-cycle line image
        for (int i = 0; i < 6; i++) begin
            send_vec(vecs[i], $sformatf("vec%0d", i));
            repeat (3) tick;
        end

        // Valid held high: 0xA5 then 0x0F must abut with no idle cycle
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick;
        tx_data = 8'h0F;
        for (int unsigned c = 1; c <= 2 * FL; c++) begin
            tick;
            if (c == 3) begin
                chk("b2b_hold_full", 32'(tx_ready), 32'd0);
                tx_valid = 1'b0;
            end
            if (c <= FL)
                chk("b2b_txd_a5", 32'(txd), 32'(line_bit(8'hA5, (c - 1) / CPB)));
            else
                chk("b2b_txd_0f", 32'(txd), 32'(line_bit(8'h0F, (c - 1 - FL) / CPB)));
            chk("b2b_busy", 32'(busy), 32'd1);
        end
        tick;
        chk("b2b_busy_end", 32'(busy), 32'd0);
        repeat (3) tick;

        // Backpressure with junk data while the hold is full
        src_q = {8'h11, 8'h22, 8'h33};
        fork
            stream_driver(0);
            stream_checker(3);
        join

        // Reset 45 cycles into 0x3C with 0x99 held: nothing may be resent
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        repeat (2) tick;
        tx_data  = 8'h99;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        repeat (42) tick;
        chk("mid_reset_pre_busy", 32'(busy), 32'd1);
        chk("mid_reset_pre_ready", 32'(tx_ready), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_reset_txd", 32'(txd), 32'd1);
        chk("mid_reset_ready", 32'(tx_ready), 32'd1);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        repeat (2) tick;
        rst = 1'b0;
        cnt = 0;
        repeat (3 * FL) begin
            tick;
            if (txd !== 1'b1 || busy !== 1'b0) cnt++;
        end
        chk("mid_reset_no_resend", cnt, 32'd0);
        send_vec(vecs[1], "after_reset_00");
        repeat (3) tick;

        // Randomized stream with random gaps
        for (int i = 0; i < 20; i++) src_q.push_back(8'($urandom));
        fork
            stream_driver(2 * FL);
            stream_checker(20);
        join

        // Default build: idle line, then measure the bit period
        cnt = 0;
        repeat (1000) begin
            tick;
            if (txd_d !== 1'b1) cnt++;
        end
        chk("def_idle_high", cnt, 32'd0);
        tx_data_d  = 8'h01;
        tx_valid_d = 1'b1;
        tick;
        tx_valid_d = 1'b0;
        guard = 0;
        while (txd_d !== 1'b0 && guard < 20) begin
            tick;
            guard++;
        end
        cnt = 0;
        while (txd_d === 1'b0 && cnt < 1000) begin
            cnt++;
            tick;
        end
        chk("def_start_period", cnt, DEF_CPB);
        cnt = 0;
        while (txd_d === 1'b1 && cnt < 1000) begin
            cnt++;
            tick;
        end
        chk("def_bit0_period", cnt, DEF_CPB);
        guard = 0;
        while (busy_d !== 1'b0 && guard < 4000) begin
            tick;
            guard++;
        end
        chk("def_frame_done", 32'(busy_d), 32'd0);
        chk("def_txd_idle", 32'(txd_d), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
